// File: rtl/pipelined_adder_pkg.sv
// Shared defaults and configuration helpers for the pipelined adder.
package pipelined_adder_pkg;

    localparam int unsigned DEFAULT_WIDTH  = 32'd16;
    localparam int unsigned DEFAULT_STAGES = 32'd4;

    function automatic int unsigned chunk_of(input int unsigned width, input int unsigned stages);
        return width / stages;
    endfunction

    function automatic bit cfg_ok(input int unsigned width, input int unsigned stages);
        return (stages >= 32'd1) && ((width % stages) == 32'd0);
    endfunction

endpackage

// File: rtl/pipelined_adder_stage.sv
// One CHUNK-bit carry-ripple slice of the pipelined adder with its own
// data/valid registers; it loads whenever it is empty or downstream accepts.
module pipelined_adder_stage #(
    parameter int unsigned WIDTH = 32'd16,
    parameter int unsigned CHUNK = 32'd4,
    parameter int unsigned IDX   = 32'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             valid_i,
    input  logic             ready_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] sum_i,
    input  logic             carry_i,
    output logic             valid_o,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);
    localparam int unsigned LSB = IDX * CHUNK;

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, sum_q, sum_d;
    logic             carry_q, carry_d;
    logic [CHUNK:0]   slice_s;
    logic             load_s;

    assign load_s = !valid_q || ready_i;

    // Slice add and next-state selection; data only moves when a real op enters.
    always_comb begin
        slice_s = {1'b0, a_i[LSB +: CHUNK]} + {1'b0, b_i[LSB +: CHUNK]} + {{CHUNK{1'b0}}, carry_i};
        valid_d = valid_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        if (load_s) begin
            valid_d = valid_i;
        end else begin
            valid_d = valid_q;
        end
        if (load_s && valid_i) begin
            a_d                = a_i;
            b_d                = b_i;
            sum_d              = sum_i;
            sum_d[LSB +: CHUNK] = slice_s[CHUNK-1:0];
            carry_d            = slice_s[CHUNK];
        end else begin
            a_d     = a_q;
            b_d     = b_q;
            sum_d   = sum_q;
            carry_d = carry_q;
        end
    end

    // Stage registers; reset drops any op held here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            a_q     <= {WIDTH{1'b0}};
            b_q     <= {WIDTH{1'b0}};
            sum_q   <= {WIDTH{1'b0}};
            carry_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
        end
    end

    assign valid_o = valid_q;
    assign a_o     = a_q;
    assign b_o     = b_q;
    assign sum_o   = sum_q;
    assign carry_o = carry_q;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit adder in STAGES registered slices with valid/ready on both sides.
// Optional subtract mode (sub port, a + ~b + 1) when PIPE_ADDER_SUB_EN is defined.
module pipelined_adder
    import pipelined_adder_pkg::*;
#(
    parameter int unsigned WIDTH  = DEFAULT_WIDTH,
    parameter int unsigned STAGES = DEFAULT_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   s
);
    localparam int unsigned CHUNK = chunk_of(WIDTH, STAGES);

    if (!cfg_ok(WIDTH, STAGES)) begin : g_cfg_err
        $error("pipelined_adder: WIDTH must be a multiple of STAGES and STAGES >= 1");
    end

    logic [STAGES-1:0] vld_s;
    logic [STAGES-1:0] rdy_s;
    logic [WIDTH-1:0]  a_s   [STAGES+1];
    logic [WIDTH-1:0]  b_s   [STAGES+1];
    logic [WIDTH-1:0]  sum_s [STAGES+1];
    logic              c_s   [STAGES+1];
    logic [WIDTH-1:0]  b0_s;
    logic              c0_s;

    // Subtract is folded into the operands so the slices only ever add.
    always_comb begin
        b0_s = b;
        c0_s = cin;
`ifdef PIPE_ADDER_SUB_EN
        if (sub) begin
            b0_s = ~b;
            c0_s = 1'b1;
        end else begin
            b0_s = b;
            c0_s = cin;
        end
`endif
    end

    assign a_s[0]   = a;
    assign b_s[0]   = b0_s;
    assign sum_s[0] = {WIDTH{1'b0}};
    assign c_s[0]   = c0_s;

    // Stage k may load if the consumer takes data or any stage from k onward is empty.
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        logic v_in_s;
        if (k == 0) begin : g_first
            assign v_in_s = in_valid;
        end else begin : g_rest
            assign v_in_s = vld_s[k-1];
        end
        assign rdy_s[k] = out_ready || !(&vld_s[STAGES-1:k]);

        pipelined_adder_stage #(
            .WIDTH (WIDTH),
            .CHUNK (CHUNK),
            .IDX   (k)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .valid_i (v_in_s),
            .ready_i (rdy_s[k]),
            .a_i     (a_s[k]),
            .b_i     (b_s[k]),
            .sum_i   (sum_s[k]),
            .carry_i (c_s[k]),
            .valid_o (vld_s[k]),
            .a_o     (a_s[k+1]),
            .b_o     (b_s[k+1]),
            .sum_o   (sum_s[k+1]),
            .carry_o (c_s[k+1])
        );
    end

    assign in_ready  = rdy_s[0];
    assign out_valid = vld_s[STAGES-1];
    assign s         = {c_s[STAGES], sum_s[STAGES]};

endmodule
